// File: rtl/pipe_prefix_addsub.sv
// Pipelined parallel-prefix adder/subtractor with valid/ready flow control,
// optional signed saturation and carry/overflow/zero flags.
module pipe_prefix_addsub #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  input  logic             sat,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LAT   = $clog2(WIDTH) + 2;
  localparam int LOG_W = LAT - 2;

  // Number of prefix levels that merged bit i: its trailing ones, capped.
  function automatic int span_log(input int i, input int cap);
    int t;
    t = 0;
    while (t < cap && ((i >> t) & 1) == 1) t++;
    return t;
  endfunction

  logic stall;

  assign stall    = out_valid && !out_ready;
  assign in_ready = rstn && !stall && !flush;

  // stg[0] holds the conditioned operands; stg[k] is the output of prefix level k.
  for (genvar k = 0; k <= LOG_W; k++) begin : stg
    logic [WIDTH-1:0] g_q, p_q, pr_q, g_d, p_d, pr_d;
    logic             c_q, am_q, bm_q, sat_q, vld_q;
    logic             c_d, am_d, bm_d, sat_d, vld_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    if (k == 0) begin : cond
      logic [WIDTH-1:0] b_eff;
      assign b_eff = sub ? ~b : b;
      assign g_d   = a & b_eff;
      assign p_d   = a ^ b_eff;
      assign pr_d  = a ^ b_eff;
      assign c_d   = sub ? ~ci : ci;
      assign am_d  = a[WIDTH-1];
      assign bm_d  = b_eff[WIDTH-1];
      assign sat_d = sat;
      assign tag_d = in_tag;
      assign vld_d = in_valid && in_ready;
    end else begin : pfx
      for (genvar i = 0; i < WIDTH; i++) begin : bit_
        if ((i % (1 << k)) == (1 << k) - 1) begin : merge
          assign g_d[i] = stg[k-1].g_q[i] |
                          (stg[k-1].p_q[i] & stg[k-1].g_q[i-(1<<(k-1))]);
          assign p_d[i] = stg[k-1].p_q[i] & stg[k-1].p_q[i-(1<<(k-1))];
        end else begin : pass
          assign g_d[i] = stg[k-1].g_q[i];
          assign p_d[i] = stg[k-1].p_q[i];
        end
      end
      assign pr_d  = stg[k-1].pr_q;
      assign c_d   = stg[k-1].c_q;
      assign am_d  = stg[k-1].am_q;
      assign bm_d  = stg[k-1].bm_q;
      assign sat_d = stg[k-1].sat_q;
      assign tag_d = stg[k-1].tag_q;
      assign vld_d = stg[k-1].vld_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_q <= 1'b0;
        g_q   <= '0;
        p_q   <= '0;
        pr_q  <= '0;
        c_q   <= 1'b0;
        am_q  <= 1'b0;
        bm_q  <= 1'b0;
        sat_q <= 1'b0;
        tag_q <= '0;
      end else begin
        if (flush)       vld_q <= 1'b0;
        else if (!stall) vld_q <= vld_d;
        if (!stall) begin
          g_q   <= g_d;
          p_q   <= p_d;
          pr_q  <= pr_d;
          c_q   <= c_d;
          am_q  <= am_d;
          bm_q  <= bm_d;
          sat_q <= sat_d;
          tag_q <= tag_d;
        end
      end
    end
  end

  logic [WIDTH-1:0] cin_v, raw, sum_d, sum_q;
  logic             co_d, ovf_d, zero_d, co_q, ovf_q, zero_q, ovld_q;
  logic [TAG_W-1:0] tag_q;

  // Down-sweep: each tree node's span extends a carry already resolved below it.
  assign cin_v[0] = stg[LOG_W].c_q;
  for (genvar i = 0; i < WIDTH; i++) begin : cry
    localparam int T  = span_log(i, LOG_W);
    localparam int LO = i + 1 - (1 << T);
    logic cy;
    if (LO == 0) begin : from_cin
      assign cy = stg[LOG_W].g_q[i] | (stg[LOG_W].p_q[i] & stg[LOG_W].c_q);
    end else begin : from_low
      assign cy = stg[LOG_W].g_q[i] | (stg[LOG_W].p_q[i] & cry[LO-1].cy);
    end
    if (i < WIDTH - 1) begin : nx
      assign cin_v[i+1] = cy;
    end
  end

  assign raw    = stg[LOG_W].pr_q ^ cin_v;
  assign co_d   = cry[WIDTH-1].cy;
  assign ovf_d  = (stg[LOG_W].am_q == stg[LOG_W].bm_q) && (raw[WIDTH-1] != stg[LOG_W].am_q);
  assign sum_d  = (stg[LOG_W].sat_q && ovf_d) ?
                  (stg[LOG_W].am_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) :
                  raw;
  assign zero_d = (sum_d == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovld_q <= 1'b0;
      sum_q  <= '0;
      co_q   <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      if (flush)       ovld_q <= 1'b0;
      else if (!stall) ovld_q <= stg[LOG_W].vld_q;
      if (!stall) begin
        sum_q  <= sum_d;
        co_q   <= co_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
        tag_q  <= stg[LOG_W].tag_q;
      end
    end
  end

  assign out_valid = ovld_q;
  assign sum       = sum_q;
  assign co        = co_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_tag   = tag_q;

endmodule

// File: doc/pipe_prefix_addsub.md
Name: pipe_prefix_addsub

Overview:
- Parametrised, fully pipelined parallel-prefix adder/subtractor with valid/ready handshake, signed saturation and status flags.
- Successor to the team's fixed 32-bit pipelined prefix adder.
- Sits in the datapath between operand-fetch and writeback.
- Accepts one operation per cycle and returns results in order after a fixed latency.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, 4..64.
- TAG_W, 4, width of the user tag carried alongside each operation.
- LAT, $clog2(WIDTH)+2 (derived, not overridable), pipeline latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline invalidate.
- in_valid  in  1  operation present.
- in_ready  out  1  pipeline can advance this cycle.
- a  in  WIDTH  operand A (two's complement).
- b  in  WIDTH  operand B (two's complement).
- ci  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = A+B+ci; 1 = A−B−ci.
- sat  in  1  1 = saturate on signed overflow.
- in_tag  in  TAG_W  user tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- co  out  1  carry-out (add); NOT-borrow (sub).
- ovf  out  1  signed overflow of the unsaturated result.
- zero  out  1  sum == 0 (post-saturation).
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: clk is the single clock; rstn is asynchronous, active-low. While rstn=0 every pipeline register, valid bit and output is 0 (in_ready=0, out_valid=0, sum=0, co=0, ovf=0, zero=0, out_tag=0). in_ready rises combinationally once rstn=1 and no stall/flush applies.
- Operand conditioning (stage 1):
  - b_eff = sub ? ~b : b.
  - c_eff = sub ? ~ci : ci.
  - P = a ^ b_eff, G = a & b_eff.
  - Register P, G, c_eff, a[WIDTH-1], b_eff[WIDTH-1], sat, tag and valid.
- Prefix stages 2..log2(WIDTH)+1: one registered level per stage. At level k, bit i with (i mod 2^k) == 2^k − 1 combines with bit i − 2^(k−1): G = Gh | (Ph & Gl), P = Ph & Pl. All other bits pass through. Stage-1 P is delayed alongside for the sum.
- Final stage (LAT): all carries from the group G/P and c_eff, registered.
  - raw = P1 ^ {C[WIDTH-1:1], c_eff}.
  - co = C[WIDTH].
  - ovf = (a_msb == b_eff_msb) && (raw_msb != a_msb).
  - sum = (sat && ovf) ? (a_msb ? 100..0 : 011..1) : raw.
  - zero = (sum == 0).
- Latency: an op accepted at edge N (in_valid && in_ready) appears on the outputs after edge N+LAT−1, i.e. is visible in the cycle after that edge. With out_ready=1, throughput is one op per cycle, strictly in order. WIDTH=32 gives LAT=7.
- Stall:
  - stall = out_valid && !out_ready; in_ready = !stall && !flush.
  - During a stall every stage holds, including bubbles; outputs stay stable. No duplication, no loss.
- Input acceptance: a stage-1 valid bit is written only when in_valid && in_ready. Input fields are ignored when in_valid=0.
- Flush:
  - On an edge with flush=1, all valid bits clear, regardless of stall. The operation offered that cycle is not accepted.
  - out_valid is 0 from the next cycle; data registers are don't-care.
- Reset asserted mid-stream: all in-flight ops are discarded immediately (asynchronous). No output is produced for them.
- Simultaneous events:
  - flush beats stall and input.
  - A stall with out_valid=0 cannot occur; bubbles never block.
- Sub-mode flags: co=1 means no borrow. ovf uses the conditioned operands, so sub overflow is detected correctly.
- ovf and co always reflect the unsaturated arithmetic.

Test Plan:
1. WIDTH=32, add, a=0x7FFFFFFF, b=1, ci=0, sat=0 → 7 cycles later sum=0x80000000, ovf=1, co=0, zero=0. Repeat with sat=1 → sum=0x7FFFFFFF, ovf=1.
2. Sub cases:
   - a=5, b=7, ci=0 → sum=0xFFFFFFFE, co=0, ovf=0.
   - a=0x80000000, b=1, ci=0 → sum=0x7FFFFFFF, co=1, ovf=1.
   - a=9, b=4, ci=1 → sum=4, co=1.
   - a=0xFFFFFFFF, b=1, add, ci=0 → sum=0, co=1, zero=1.
3. Stream 1000 random ops (random sub/sat/ci/tag), out_ready=1 → one result per cycle, in order, matching the reference model, and out_tag equal to the input tag.
4. Fill the pipeline, then hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 throughout, outputs frozen. On release the results continue with no drop or duplicate. Also random out_ready at 30% gives the same sequence as test 3.
5. Flush with 4 ops in flight, plus a new op offered in the same cycle → out_valid=0 for all of them; an op issued next cycle emerges after 7 cycles. Repeat using rstn pulsed low mid-stream → every output is 0 immediately and no stale result appears.
6. WIDTH=8 (LAT=5): a=0xFF, b=0x01, ci=1 → sum=0x01, co=1, ovf=0, after 5 cycles. a=0x80, b=0x01, sub, sat=1 → sum=0x80, ovf=1.
